mult_issue_ctrl: RTL

MULT_ISSUE_CTRL -- requirements
Module: mult_issue_ctrl

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_issue_ctrl_if.sv | 26 ++
 rtl/mult_issue_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier issue controller and its neighbours.
package mult_pkg;

  localparam int DATA_W       = 32;
  localparam int OPB_W        = 16;
  localparam int TAG_W        = 5;
  localparam int CNT_W        = 4;
  localparam int MULT_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand B must be a sign-extended 16-bit value for the narrow multiplier.
  function automatic logic opb_fits(input logic [DATA_W-1:0] b);
    return b[DATA_W-1:OPB_W] == {(DATA_W-OPB_W){b[OPB_W-1]}};
  endfunction

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// Request/response handshake bundle between an issuer and the multiplier issue controller.
interface mult_issue_ctrl_if;
  import mult_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_opA;
  logic [DATA_W-1:0] req_opB;
  logic [TAG_W-1:0]  req_tag;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_result;
  logic              resp_exception;
  logic [TAG_W-1:0]  resp_tag;

  modport master (
    output req_valid, req_opA, req_opB, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_exception, resp_tag
  );

  modport slave (
    input  req_valid, req_opA, req_opB, req_tag, resp_ready,
    output req_ready, resp_valid, resp_result, resp_exception, resp_tag
  );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Purpose: issues one request at a time to an external multiplier, with range check and timeout.
// Latency: response valid one cycle after resultRDY is sampled (one cycle after accept on range error).
// Backpressure: one op in flight; req_ready only in IDLE, response held until resp_ready or flush.
module mult_issue_ctrl
  import mult_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  mult_issue_ctrl_if.slave  bus,
  output logic              busy,
  output logic [DATA_W-1:0] mult_opA,
  output logic [OPB_W-1:0]  mult_opB,
  output logic              mult_ctrl,
  input  logic [DATA_W-1:0] mult_result,
  input  logic              mult_exception,
  input  logic              mult_resultRDY,
  input  logic              mult_inputRDY
);

  state_t             state_q, state_d;
  logic               run_q;
  logic [DATA_W-1:0]  opa_q;
  logic [OPB_W-1:0]   opb_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  res_q;
  logic               exc_q;
  logic               accept;
  logic               timeout;
  logic               unused_ok;

  assign unused_ok = mult_inputRDY;
  assign accept    = (state_q == IDLE) && bus.req_valid && !flush;
  assign timeout   = (cnt_q == CNT_W'(MULT_TIMEOUT - 1));

  // run_q mirrors state RUN as its own flop so mult_ctrl never sees comb glitches.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = opb_fits(bus.req_opB) ? RUN : DONE;
      RUN: begin
        if (flush)                          state_d = IDLE;
        else if (mult_resultRDY || timeout) state_d = DONE;
      end
      DONE: if (flush || bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready      = (state_q == IDLE);
    bus.resp_valid     = (state_q == DONE);
    busy               = (state_q != IDLE);
    mult_ctrl          = run_q;
    mult_opA           = opa_q;
    mult_opB           = opb_q;
    bus.resp_result    = res_q;
    bus.resp_exception = exc_q;
    bus.resp_tag       = tag_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      opa_q <= '0;
      opb_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      exc_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            opa_q <= bus.req_opA;
            opb_q <= bus.req_opB[OPB_W-1:0];
            tag_q <= bus.req_tag;
            cnt_q <= '0;
            res_q <= '0;
            exc_q <= !opb_fits(bus.req_opB);
          end
        end
        RUN: begin
          if (!flush) begin
            // A result arriving on the timeout cycle takes precedence.
            if (mult_resultRDY) begin
              res_q <= mult_result;
              exc_q <= mult_exception;
            end else if (timeout) begin
              res_q <= '0;
              exc_q <= 1'b1;
            end
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
